demux14x16_buf: RTL and testbench

Buffered 1-to-4 demultiplexer that steers one `DATAWIDTH`-bit source word to one of four destination channels, using ready/valid handshakes on every side. It is the inverse of the 4:1 source-select mux that feeds the register-file bus. Results leaving a single producer (ALU/load path) are routed to up to four consumers (register-file write port, memory write data, I/O port, forwarding latch). Each consumer gets a one-entry holding register, so a slow consumer stalls only traffic addressed to it.

---
 rtl/demux14x16_buf.sv | 118 +++++++++++
 tb/tb_demux14x16_buf.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/demux14x16_buf.sv
// ---------------------------------------------------------------------------
// demux14x16_buf
//   Buffered 1-to-4 demultiplexer. One DATAWIDTH-bit source word is steered
//   to one of four consumer channels. Each channel has a one-entry holding
//   register, so a slow consumer only stalls traffic addressed to it.
//
// Ports
//   clk               system clock, rising edge
//   reset             synchronous, active-high reset
//   in_valid          source word present
//   in_ready          selected channel (or all channels when broadcasting)
//                     can take a word this cycle; combinational
//   cntrl[1:0]        destination channel select
//   din               source word
//   dout0..dout3      channel holding registers
//   valid0..valid3    channel holds an undelivered word
//   ready0..ready3    consumer takes the word this cycle
//   stall_cnt         saturating count of cycles with in_valid & ~in_ready
//   bcast             broadcast request (only with DEMUX_BROADCAST_EN)
//
// Build option
//   DEMUX_BROADCAST_EN  adds the bcast port; with bcast=1 a word is loaded
//                       into all four channels once all four are free.
// ---------------------------------------------------------------------------
module demux14x16_buf #(
    parameter int DATAWIDTH = 16,
    parameter int CNT_W     = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [1:0]           cntrl,
    input  logic [DATAWIDTH-1:0] din,
    output logic [DATAWIDTH-1:0] dout0,
    output logic [DATAWIDTH-1:0] dout1,
    output logic [DATAWIDTH-1:0] dout2,
    output logic [DATAWIDTH-1:0] dout3,
    output logic                 valid0,
    output logic                 valid1,
    output logic                 valid2,
    output logic                 valid3,
    input  logic                 ready0,
    input  logic                 ready1,
    input  logic                 ready2,
    input  logic                 ready3,
    output logic [CNT_W-1:0]     stall_cnt
`ifdef DEMUX_BROADCAST_EN
    ,
    input  logic                 bcast
`endif
);

    logic [DATAWIDTH-1:0] hold [4];
    logic [3:0]           full;
    logic [3:0]           rdy;
    logic [3:0]           free;
    logic [3:0]           load;
    logic                 accept;

    assign rdy  = {ready3, ready2, ready1, ready0};

    // A channel can take a new word if it is empty or is being drained now.
    assign free = ~full | rdy;

`ifdef DEMUX_BROADCAST_EN
    assign in_ready = bcast ? (&free) : free[cntrl];
`else
    assign in_ready = free[cntrl];
`endif

    assign accept = in_valid & in_ready;

    always_comb begin
        load = '0;
        for (int n = 0; n < 4; n++) begin
`ifdef DEMUX_BROADCAST_EN
            load[n] = accept & (bcast | (cntrl == 2'(n)));
`else
            load[n] = accept & (cntrl == 2'(n));
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            full      <= '0;
            stall_cnt <= '0;
            for (int n = 0; n < 4; n++) begin
                hold[n] <= '0;
            end
        end else begin
            for (int n = 0; n < 4; n++) begin
                // A load wins over a drain so that accept+drain keeps the
                // channel full with the new word and no bubble.
                if (load[n]) begin
                    hold[n] <= din;
                    full[n] <= 1'b1;
                end else if (rdy[n]) begin
                    full[n] <= 1'b0;
                end
            end
            if (in_valid && !in_ready && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
        end
    end

    assign dout0  = hold[0];
    assign dout1  = hold[1];
    assign dout2  = hold[2];
    assign dout3  = hold[3];
    assign valid0 = full[0];
    assign valid1 = full[1];
    assign valid2 = full[2];
    assign valid3 = full[3];

endmodule

// File: tb/tb_demux14x16_buf.sv
// ---------------------------------------------------------------------------
// tb_demux14x16_buf
//   Scoreboard bench for demux14x16_buf. Every accepted word is pushed to a
//   per-channel queue; every word taken by a consumer is popped and compared.
//   A small reference model tracks full flags, holding registers and the
//   stall counter independently of the DUT.
// ---------------------------------------------------------------------------
module tb_demux14x16_buf;

    localparam int DW    = 16;
    localparam int CNT_W = 8;

    logic            clk = 1'b0;
    logic            reset;
    logic            in_valid;
    logic            in_ready;
    logic [1:0]      cntrl;
    logic [DW-1:0]   din;
    logic [DW-1:0]   dout0, dout1, dout2, dout3;
    logic            valid0, valid1, valid2, valid3;
    logic            ready0, ready1, ready2, ready3;
    logic [CNT_W-1:0] stall_cnt;
    logic            bcast;

    always #5 clk = ~clk;

    demux14x16_buf #(.DATAWIDTH(DW), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .cntrl     (cntrl),
        .din       (din),
        .dout0     (dout0),
        .dout1     (dout1),
        .dout2     (dout2),
        .dout3     (dout3),
        .valid0    (valid0),
        .valid1    (valid1),
        .valid2    (valid2),
        .valid3    (valid3),
        .ready0    (ready0),
        .ready1    (ready1),
        .ready2    (ready2),
        .ready3    (ready3),
        .stall_cnt (stall_cnt)
`ifdef DEMUX_BROADCAST_EN
        ,
        .bcast     (bcast)
`endif
    );

    int n_vec = 0;
    int n_bad = 0;

    logic [DW-1:0]    q [4][$];
    logic [3:0]       m_full;
    logic [DW-1:0]    m_hold [4];
    logic [CNT_W-1:0] m_stall;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] dout_of(input int n);
        case (n)
            0: return dout0;
            1: return dout1;
            2: return dout2;
            default: return dout3;
        endcase
    endfunction

    // Called just after a falling edge once inputs are driven: checks state
    // and handshakes against the model, then advances the model over the
    // next rising edge.
    task automatic cycle();
        logic [3:0] r;
        logic [3:0] fr;
        logic       exp_rdy;
        logic [DW-1:0] w;
        #1;
        r  = {ready3, ready2, ready1, ready0};
        fr = ~m_full | r;
        exp_rdy = fr[cntrl];
`ifdef DEMUX_BROADCAST_EN
        if (bcast) exp_rdy = &fr;
`endif
        check("valid", {28'd0, valid3, valid2, valid1, valid0}, {28'd0, m_full});
        for (int n = 0; n < 4; n++)
            check($sformatf("dout%0d", n), {16'd0, dout_of(n)}, {16'd0, m_hold[n]});
        check("stall_cnt", {24'd0, stall_cnt}, {24'd0, m_stall});
        check("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});

        for (int n = 0; n < 4; n++) begin
            if (m_full[n] && r[n]) begin
                check($sformatf("q%0d_nonempty", n), {31'd0, q[n].size() != 0}, 32'd1);
                if (q[n].size() != 0) begin
                    w = q[n].pop_front();
                    check($sformatf("deliver%0d", n), {16'd0, dout_of(n)}, {16'd0, w});
                end
                m_full[n] = 1'b0;
            end
        end

        if (in_valid && exp_rdy) begin
            for (int n = 0; n < 4; n++) begin
                logic hit;
                hit = (cntrl == 2'(n));
`ifdef DEMUX_BROADCAST_EN
                if (bcast) hit = 1'b1;
`endif
                if (hit) begin
                    q[n].push_back(din);
                    m_hold[n] = din;
                    m_full[n] = 1'b1;
                end
            end
        end else if (in_valid && m_stall != {CNT_W{1'b1}}) begin
            m_stall = m_stall + 1'b1;
        end

        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        in_valid = 1'b0;
        cntrl    = 2'd0;
        din      = '0;
        bcast    = 1'b0;
        {ready3, ready2, ready1, ready0} = 4'b0000;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int n = 0; n < 4; n++) begin
            q[n].delete();
            m_hold[n] = '0;
        end
        m_full  = '0;
        m_stall = '0;
        cycle();
    endtask

    task automatic send(input logic [1:0] ch, input logic [DW-1:0] d);
        in_valid = 1'b1;
        cntrl    = ch;
        din      = d;
        cycle();
        in_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();

        // Reset then idle: in_ready must be 1 with all channels empty.
        do_reset();
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);

        // Unicast to each channel, consumers not ready.
        for (int n = 0; n < 4; n++) send(2'(n), 16'hA000 + 16'(n));
        in_valid = 1'b1; cntrl = 2'd2; din = 16'hA0FF;
        #1;
        check("repeat_ch2_in_ready", {31'd0, in_ready}, 32'd0);
        cycle();
        in_valid = 1'b0;
        {ready3, ready2, ready1, ready0} = 4'b1111;
        cycle();
        idle_inputs();
        cycle();

        // Back-to-back streaming on channel 1.
        ready1 = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            in_valid = 1'b1; cntrl = 2'd1; din = 16'(i);
            cycle();
        end
        in_valid = 1'b0;
        cycle();
        check("stream_drained", {31'd0, valid1}, 32'd0);
        idle_inputs();

        // Blocked channel 0 while channel 3 drains independently.
        send(2'd0, 16'h0C0C);
        ready3 = 1'b1;
        send(2'd3, 16'h1234);
        cycle();
        check("ch0_still_held", {15'd0, valid0, dout0}, {15'd0, 1'b1, 16'h0C0C});
        idle_inputs();

        // Stall counter saturation on a full channel 2.
        send(2'd2, 16'h2222);
        in_valid = 1'b1; cntrl = 2'd2; din = 16'h5555;
        for (int i = 0; i < 300; i++) cycle();
        in_valid = 1'b0;
        cycle();
        check("stall_sat", {24'd0, stall_cnt}, 32'd255);
        check("dout2_kept", {16'd0, dout2}, 32'h2222);

`ifdef DEMUX_BROADCAST_EN
        // Broadcast blocked by a full channel 1 until it drains.
        do_reset();
        send(2'd1, 16'h1111);
        in_valid = 1'b1; bcast = 1'b1; din = 16'hBEEF;
        #1;
        check("bcast_blocked", {31'd0, in_ready}, 32'd0);
        cycle();
        ready1 = 1'b1;
        cycle();
        ready1 = 1'b0; in_valid = 1'b0; bcast = 1'b0;
        #1;
        check("bcast_all", {4'd0, dout3, dout2[3:0], valid3, valid2, valid1, valid0, 4'd0},
              {4'd0, 16'hBEEF, 4'hF, 4'b1111, 4'd0});
        cycle();
`endif

        // Reset mid-operation discards held words.
        send(2'd1, 16'h7777);
        do_reset();
        check("mid_reset_valid1", {31'd0, valid1}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
